seq_debug_cmd_ctrl: RTL and testbench

Avalon-MM master that issues debug commands to the LPDDR2 sequencer core's command mailbox. It writes parameter words and the request-command word into the sequencer debug region, polls the status word until the sequencer reports completion, clears the status, and returns the result to a single requester. It sits between the host/JTAG debug bridge and the sequencer's Avalon slave port.

---
 rtl/seq_debug_cmd_ctrl.sv | 232 +++++++++++++++++++++++
 tb/tb_seq_debug_cmd_ctrl.sv | 360 ++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/seq_debug_cmd_ctrl.sv
// Avalon-MM master that posts a debug command into the sequencer mailbox and polls for completion.
// Build with SEQ_DBG_TIMEOUT_EN defined to add the saturating poll timeout (rsp_status 2).
module seq_debug_cmd_ctrl #(
   parameter logic [31:0] CMD_BASE       = 32'h0001_52AC,
   parameter int          NUM_PARAMS     = 4,
   parameter int          POLL_GAP       = 16,
   parameter logic [31:0] TIMEOUT_CYCLES = 32'd65535
) (
   input  logic                     clk,
   input  logic                     reset,
   input  logic                     cmd_valid,
   output logic                     cmd_ready,
   input  logic [31:0]              cmd_code,
   input  logic [32*NUM_PARAMS-1:0] cmd_params,
   output logic                     rsp_valid,
   output logic [1:0]               rsp_status,
   output logic [31:0]              rsp_data,
   output logic [31:0]              avm_address,
   output logic                     avm_write,
   output logic                     avm_read,
   output logic [31:0]              avm_writedata,
   input  logic [31:0]              avm_readdata,
   input  logic                     avm_waitrequest,
   input  logic                     avm_readdatavalid
);
   localparam int IDX_W = $clog2(NUM_PARAMS) + 1;
   localparam int SEL_W = (NUM_PARAMS > 1) ? $clog2(NUM_PARAMS) : 1;
   localparam int GAP_W = $clog2(POLL_GAP) + 1;
   localparam logic [31:0] STAT_ADDR  = CMD_BASE + 32'd4;
   localparam logic [31:0] PARAM_ADDR = CMD_BASE + 32'd8;

   typedef enum logic [2:0] {
      IDLE, WR_PARAM, WR_CMD, RD_STAT, WAIT_RD, GAP, CLR_STAT, RESP
   } state_t;

   state_t           state_q, state_d;
   logic [IDX_W-1:0] idx_q, idx_d;
   logic [GAP_W-1:0] gap_q, gap_d;
   logic [31:0]      code_q, code_d;
   logic [31:0]      param_q [NUM_PARAMS];
   logic [31:0]      param_d [NUM_PARAMS];
   logic [31:0]      param_in [NUM_PARAMS];
   logic             cmd_ready_q, cmd_ready_d;
   logic             rsp_valid_q, rsp_valid_d;
   logic [1:0]       rsp_status_q, rsp_status_d;
   logic [31:0]      rsp_data_q, rsp_data_d;
   logic [31:0]      addr_q, addr_d;
   logic             write_q, write_d;
   logic             read_q, read_d;
   logic [31:0]      wdata_q, wdata_d;
   logic             clr_go;
   logic             timed_out;

   for (genvar gi = 0; gi < NUM_PARAMS; gi++) begin : g_unpack
      assign param_in[gi] = cmd_params[32*gi +: 32];
   end

`ifdef SEQ_DBG_TIMEOUT_EN
   logic [31:0] tmo_q, tmo_d;

   // Counts only while polling; held at all-ones instead of wrapping.
   always_comb begin
      tmo_d = tmo_q;
      if (state_q == WR_CMD && !avm_waitrequest) begin
         tmo_d = '0;
      end else if ((state_q == RD_STAT || state_q == WAIT_RD || state_q == GAP) && tmo_q != '1) begin
         tmo_d = tmo_q + 32'd1;
      end
   end

   assign timed_out = (tmo_q >= TIMEOUT_CYCLES);
`else
   assign timed_out = 1'b0;
`endif

   always_comb begin
      state_d      = state_q;
      idx_d        = idx_q;
      gap_d        = gap_q;
      code_d       = code_q;
      param_d      = param_q;
      cmd_ready_d  = cmd_ready_q;
      rsp_valid_d  = 1'b0;
      rsp_status_d = rsp_status_q;
      rsp_data_d   = rsp_data_q;
      addr_d       = addr_q;
      write_d      = write_q;
      read_d       = read_q;
      wdata_d      = wdata_q;
      clr_go       = 1'b0;

      unique case (state_q)
         IDLE: begin
            if (cmd_valid) begin
               code_d      = cmd_code;
               param_d     = param_in;
               idx_d       = '0;
               cmd_ready_d = 1'b0;
               write_d     = 1'b1;
               addr_d      = PARAM_ADDR;
               wdata_d     = param_in[0];
               state_d     = WR_PARAM;
            end
         end
         WR_PARAM: begin
            if (!avm_waitrequest) begin
               if (idx_q == IDX_W'(NUM_PARAMS - 1)) begin
                  addr_d  = CMD_BASE;
                  wdata_d = code_q;
                  state_d = WR_CMD;
               end else begin
                  idx_d   = idx_q + 1'b1;
                  addr_d  = PARAM_ADDR + (32'(idx_d) << 2);
                  wdata_d = param_q[idx_d[SEL_W-1:0]];
               end
            end
         end
         WR_CMD: begin
            if (!avm_waitrequest) begin
               write_d = 1'b0;
               read_d  = 1'b1;
               addr_d  = STAT_ADDR;
               state_d = RD_STAT;
            end
         end
         // A read already on the bus is never withdrawn; a timeout is acted on once its data returns.
         RD_STAT: begin
            if (!avm_waitrequest) begin
               read_d  = 1'b0;
               state_d = WAIT_RD;
            end
         end
         WAIT_RD: begin
            if (avm_readdatavalid) begin
               rsp_data_d = avm_readdata;
               if (avm_readdata[7:0] == 8'h02) begin
                  rsp_status_d = 2'd0;
                  clr_go       = 1'b1;
               end else if (avm_readdata[7:0] == 8'h03) begin
                  rsp_status_d = 2'd1;
                  clr_go       = 1'b1;
               end else if (timed_out) begin
                  rsp_status_d = 2'd2;
                  clr_go       = 1'b1;
               end else begin
                  gap_d   = '0;
                  state_d = GAP;
               end
            end
         end
         GAP: begin
            if (timed_out) begin
               rsp_status_d = 2'd2;
               clr_go       = 1'b1;
            end else if (gap_q == GAP_W'(POLL_GAP - 1)) begin
               read_d  = 1'b1;
               addr_d  = STAT_ADDR;
               state_d = RD_STAT;
            end else begin
               gap_d = gap_q + 1'b1;
            end
         end
         CLR_STAT: begin
            if (!avm_waitrequest) begin
               write_d     = 1'b0;
               rsp_valid_d = 1'b1;
               state_d     = RESP;
            end
         end
         RESP: begin
            cmd_ready_d = 1'b1;
            state_d     = IDLE;
         end
         default: state_d = IDLE;
      endcase

      if (clr_go) begin
         write_d = 1'b1;
         addr_d  = STAT_ADDR;
         wdata_d = 32'd0;
         state_d = CLR_STAT;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q      <= IDLE;
         idx_q        <= '0;
         gap_q        <= '0;
         code_q       <= '0;
         for (int i = 0; i < NUM_PARAMS; i++) param_q[i] <= '0;
         cmd_ready_q  <= 1'b1;
         rsp_valid_q  <= 1'b0;
         rsp_status_q <= 2'd0;
         rsp_data_q   <= '0;
         addr_q       <= '0;
         write_q      <= 1'b0;
         read_q       <= 1'b0;
         wdata_q      <= '0;
`ifdef SEQ_DBG_TIMEOUT_EN
         tmo_q        <= '0;
`endif
      end else begin
         state_q      <= state_d;
         idx_q        <= idx_d;
         gap_q        <= gap_d;
         code_q       <= code_d;
         param_q      <= param_d;
         cmd_ready_q  <= cmd_ready_d;
         rsp_valid_q  <= rsp_valid_d;
         rsp_status_q <= rsp_status_d;
         rsp_data_q   <= rsp_data_d;
         addr_q       <= addr_d;
         write_q      <= write_d;
         read_q       <= read_d;
         wdata_q      <= wdata_d;
`ifdef SEQ_DBG_TIMEOUT_EN
         tmo_q        <= tmo_d;
`endif
      end
   end

   // Held low while reset is asserted so the requester never sees a ready idle flop mid-reset.
   assign cmd_ready     = cmd_ready_q & ~reset;
   assign rsp_valid     = rsp_valid_q;
   assign rsp_status    = rsp_status_q;
   assign rsp_data      = rsp_data_q;
   assign avm_address   = addr_q;
   assign avm_write     = write_q;
   assign avm_read      = read_q;
   assign avm_writedata = wdata_q;
endmodule

// File: tb/tb_seq_debug_cmd_ctrl.sv
// Bench for seq_debug_cmd_ctrl: a stalling Avalon slave with scripted status words, checked
// against an expected bus-transaction list built from the mailbox protocol rules.
`timescale 1ns/1ps
module tb_seq_debug_cmd_ctrl;
   localparam logic [31:0] CMD_BASE  = 32'h0001_52AC;
   localparam logic [31:0] STAT_ADDR = 32'h0001_52B0;
   localparam int NP       = 4;
   localparam int POLL_GAP = 16;
   localparam int TMO      = 100;

   typedef struct { logic wr; logic [31:0] addr; logic [31:0] data; int cyc; } xact_t;
   typedef struct { logic [1:0] st; logic [31:0] data; int cyc; } rsp_t;

   logic             clk = 1'b0;
   logic             reset = 1'b1;
   logic             cmd_valid = 1'b0;
   logic             cmd_ready;
   logic [31:0]      cmd_code = '0;
   logic [32*NP-1:0] cmd_params = '0;
   logic             rsp_valid;
   logic [1:0]       rsp_status;
   logic [31:0]      rsp_data;
   logic [31:0]      avm_address;
   logic             avm_write;
   logic             avm_read;
   logic [31:0]      avm_writedata;
   logic [31:0]      avm_readdata = '0;
   logic             avm_waitrequest = 1'b0;
   logic             avm_readdatavalid = 1'b0;

   int          tests = 0;
   int          fails = 0;
   int          cyc = 0;
   int          max_wait = 0;
   int          stable_viol = 0;
   xact_t       log_q[$];
   xact_t       exp_q[$];
   rsp_t        rsp_q[$];
   logic [31:0] stat_q[$];
   logic [1:0]  exp_status;
   logic [31:0] exp_data;

   seq_debug_cmd_ctrl #(
      .CMD_BASE(CMD_BASE), .NUM_PARAMS(NP), .POLL_GAP(POLL_GAP), .TIMEOUT_CYCLES(32'(TMO))
   ) dut (
      .clk(clk), .reset(reset), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
      .cmd_code(cmd_code), .cmd_params(cmd_params), .rsp_valid(rsp_valid),
      .rsp_status(rsp_status), .rsp_data(rsp_data), .avm_address(avm_address),
      .avm_write(avm_write), .avm_read(avm_read), .avm_writedata(avm_writedata),
      .avm_readdata(avm_readdata), .avm_waitrequest(avm_waitrequest),
      .avm_readdatavalid(avm_readdatavalid)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   // Slave: decides stalls on the falling edge, logs each accepted transfer, returns
   // read data one cycle after acceptance, and flags any change while stalled.
   initial begin : slave
      int          stall;
      bit          busy;
      bit          rd_pend;
      logic [31:0] rd_data;
      logic        s_wr;
      logic [31:0] s_addr, s_data;
      stall = 0; busy = 0; rd_pend = 0; rd_data = '0; s_wr = 0; s_addr = '0; s_data = '0;
      forever begin
         @(negedge clk);
         avm_readdatavalid = rd_pend;
         avm_readdata      = rd_pend ? rd_data : 32'h0;
         rd_pend = 0;
         if (reset) begin
            busy = 0; avm_waitrequest = 0; avm_readdatavalid = 0;
         end else if (avm_write || avm_read) begin
            if (!busy) begin
               busy = 1; stall = $urandom_range(max_wait, 0);
               s_wr = avm_write; s_addr = avm_address; s_data = avm_writedata;
            end else if (avm_write !== s_wr || avm_read !== !s_wr || avm_address !== s_addr ||
                         (s_wr && avm_writedata !== s_data)) begin
               stable_viol++;
            end
            if (stall > 0) begin
               avm_waitrequest = 1; stall--;
            end else begin
               avm_waitrequest = 0; busy = 0;
               log_q.push_back('{avm_write, avm_address, avm_writedata, cyc});
               if (avm_read) begin
                  rd_pend = 1;
                  rd_data = (stat_q.size() > 0) ? stat_q.pop_front() : 32'h0000_0001;
               end
            end
         end else begin
            avm_waitrequest = 0;
         end
      end
   end

   initial begin : rsp_mon
      forever begin
         @(negedge clk);
         if (rsp_valid === 1'b1) rsp_q.push_back('{rsp_status, rsp_data, cyc});
      end
   end

   initial begin : watchdog
      #600000;
      $display("FAIL watchdog: simulation exceeded time limit");
      $fatal(1, "watchdog");
   end

   // Reference: every param write in index order, the command word, one status read per
   // scripted word up to the first done/error, then the status clear.
   function automatic void model(input logic [31:0] code, input logic [31:0] prm [NP],
                                 input logic [31:0] script [$]);
      exp_q.delete();
      exp_status = 2'd3;
      exp_data   = 32'h0;
      for (int i = 0; i < NP; i++) exp_q.push_back('{1'b1, CMD_BASE + 32'd8 + 32'(4 * i), prm[i], 0});
      exp_q.push_back('{1'b1, CMD_BASE, code, 0});
      foreach (script[k]) begin
         exp_q.push_back('{1'b0, CMD_BASE + 32'd4, 32'h0, 0});
         if (script[k][7:0] == 8'h02 || script[k][7:0] == 8'h03) begin
            exp_status = (script[k][7:0] == 8'h02) ? 2'd0 : 2'd1;
            exp_data   = script[k];
            break;
         end
      end
      exp_q.push_back('{1'b1, CMD_BASE + 32'd4, 32'h0, 0});
   endfunction

   function automatic int log_diff();
      if (log_q.size() != exp_q.size()) return -2;
      foreach (exp_q[i])
         if (log_q[i].wr !== exp_q[i].wr || log_q[i].addr !== exp_q[i].addr ||
             (exp_q[i].wr && log_q[i].data !== exp_q[i].data)) return i;
      return -1;
   endfunction

   function automatic logic [31:0] busy_word();
      logic [31:0] w;
      w = $urandom;
      if (w[7:0] == 8'h02 || w[7:0] == 8'h03) w[7:0] = 8'h01;
      return w;
   endfunction

   task automatic issue(input logic [31:0] code, input logic [31:0] prm [NP],
                        input logic [31:0] script [$], output int cmd_cyc, output bit ok);
      log_q.delete(); rsp_q.delete(); stat_q = script;
      @(negedge clk);
      cmd_code = code;
      for (int i = 0; i < NP; i++) cmd_params[32*i +: 32] = prm[i];
      cmd_valid = 1;
      for (int t = 0; t < 50 && cmd_ready !== 1'b1; t++) @(negedge clk);
      cmd_cyc = cyc;
      @(negedge clk);
      cmd_valid = 0;
      ok = 0;
      for (int t = 0; t < 3000; t++) begin
         @(negedge clk); #2;
         if (rsp_q.size() > 0) begin ok = 1; break; end
      end
      repeat (3) @(negedge clk);
   endtask

   task automatic test_reset();
      repeat (3) @(negedge clk);
      tests++; if (cmd_ready !== 1'b0) begin fails++; $display("FAIL reset_ready: got %b want 0", cmd_ready); end
      tests++; if ({avm_write, avm_read, rsp_valid} !== 3'b000) begin fails++; $display("FAIL reset_strobes: got %b want 000", {avm_write, avm_read, rsp_valid}); end
      tests++; if ({avm_address, avm_writedata, rsp_data, rsp_status} !== '0) begin fails++; $display("FAIL reset_data: addr=%h wd=%h rd=%h st=%0d want 0", avm_address, avm_writedata, rsp_data, rsp_status); end
      reset = 0;
      @(negedge clk);
      tests++; if (cmd_ready !== 1'b1) begin fails++; $display("FAIL reset_ready_after: got %b want 1", cmd_ready); end
      $display("[TB] reset done");
   endtask

   task automatic test_basic();
      logic [31:0] prm [NP];
      logic [31:0] scr [$];
      int cc, d;
      bit ok;
      for (int i = 0; i < NP; i++) prm[i] = 32'(i + 1);
      scr.push_back(32'h0000_0002);
      max_wait = 0;
      model(32'h0000_0011, prm, scr);
      issue(32'h0000_0011, prm, scr, cc, ok);
      tests++; if (!ok) begin fails++; $display("FAIL basic_rsp: no rsp_valid, want one"); end
      d = log_diff();
      tests++; if (d != -1) begin fails++; $display("FAIL basic_log: diff at %0d (got %0d xacts, want %0d)", d, log_q.size(), exp_q.size()); end
      if (ok) begin
         tests++; if (rsp_q[0].st !== exp_status) begin fails++; $display("FAIL basic_status: got %0d want %0d", rsp_q[0].st, exp_status); end
         tests++; if (rsp_q[0].data !== exp_data) begin fails++; $display("FAIL basic_data: got %h want %h", rsp_q[0].data, exp_data); end
         tests++; if (rsp_q[0].cyc - cc !== NP + 5) begin fails++; $display("FAIL basic_latency: got %0d want %0d", rsp_q[0].cyc - cc, NP + 5); end
         tests++; if (rsp_q.size() !== 1) begin fails++; $display("FAIL basic_rsp_count: got %0d want 1", rsp_q.size()); end
         $display("[TB] basic code=11 status=%0d data=%h latency=%0d", rsp_q[0].st, rsp_q[0].data, rsp_q[0].cyc - cc);
      end
      if (log_q.size() > 0) begin
         tests++; if (log_q[0].cyc - cc !== 1) begin fails++; $display("FAIL basic_first_write: got %0d want 1", log_q[0].cyc - cc); end
      end
   endtask

   task automatic test_error_poll();
      logic [31:0] prm [NP];
      logic [31:0] scr [$];
      int cc, d, nrd, last, min_gap;
      bit ok;
      for (int i = 0; i < NP; i++) prm[i] = $urandom;
      scr = '{32'h0000_0001, 32'h0000_0001, 32'h0000_0001, 32'h0000_0003};
      max_wait = 0;
      model(32'h0000_0022, prm, scr);
      issue(32'h0000_0022, prm, scr, cc, ok);
      nrd = 0; last = -1000; min_gap = 1000;
      foreach (log_q[i]) if (!log_q[i].wr) begin
         if (nrd > 0 && log_q[i].cyc - last < min_gap) min_gap = log_q[i].cyc - last;
         last = log_q[i].cyc; nrd++;
      end
      tests++; if (!ok) begin fails++; $display("FAIL err_rsp: no rsp_valid, want one"); end
      d = log_diff();
      tests++; if (d != -1) begin fails++; $display("FAIL err_log: diff at %0d (got %0d xacts, want %0d)", d, log_q.size(), exp_q.size()); end
      tests++; if (nrd !== 4) begin fails++; $display("FAIL err_reads: got %0d want 4", nrd); end
      tests++; if (min_gap < POLL_GAP + 1) begin fails++; $display("FAIL err_spacing: got %0d want >=%0d", min_gap, POLL_GAP + 1); end
      if (ok) begin
         tests++; if (rsp_q[0].st !== 2'd1) begin fails++; $display("FAIL err_status: got %0d want 1", rsp_q[0].st); end
         tests++; if (rsp_q[0].data !== 32'h3) begin fails++; $display("FAIL err_data: got %h want 00000003", rsp_q[0].data); end
         $display("[TB] error_poll reads=%0d spacing=%0d status=%0d", nrd, min_gap, rsp_q[0].st);
      end
   endtask

   task automatic test_waitrequest();
      logic [31:0] prm [NP];
      logic [31:0] scr [$];
      logic [31:0] code, fin;
      int cc, d, nb;
      bit ok;
      max_wait = 5;
      for (int it = 0; it < 5; it++) begin
         code = $urandom;
         for (int i = 0; i < NP; i++) prm[i] = $urandom;
         scr.delete();
         nb = $urandom_range(2, 0);
         for (int k = 0; k < nb; k++) scr.push_back(busy_word());
         fin = $urandom;
         fin[7:0] = ($urandom_range(1, 0) == 0) ? 8'h02 : 8'h03;
         scr.push_back(fin);
         stable_viol = 0;
         model(code, prm, scr);
         issue(code, prm, scr, cc, ok);
         d = log_diff();
         tests++; if (d != -1) begin fails++; $display("FAIL wait_log[%0d]: diff at %0d (got %0d xacts, want %0d)", it, d, log_q.size(), exp_q.size()); end
         tests++; if (stable_viol !== 0) begin fails++; $display("FAIL wait_stable[%0d]: got %0d changes while stalled want 0", it, stable_viol); end
         tests++; if (!ok) begin fails++; $display("FAIL wait_rsp[%0d]: no rsp_valid, want one", it); end
         else begin
            tests++; if (rsp_q[0].st !== exp_status || rsp_q[0].data !== exp_data) begin
               fails++; $display("FAIL wait_result[%0d]: got %0d/%h want %0d/%h", it, rsp_q[0].st, rsp_q[0].data, exp_status, exp_data);
            end
            $display("[TB] waitreq code=%h busy=%0d status=%0d data=%h", code, nb, rsp_q[0].st, rsp_q[0].data);
         end
      end
      max_wait = 0;
   endtask

   task automatic test_reset_mid();
      logic [31:0] prm [NP];
      logic [31:0] scr [$];
      int cc, d;
      bit ok, seen;
      log_q.delete(); rsp_q.delete(); stat_q.delete();
      stat_q.push_back(32'h0000_0002);
      max_wait = 0;
      @(negedge clk);
      cmd_code = 32'h0000_0055;
      cmd_valid = 1;
      @(negedge clk);
      cmd_valid = 0;
      seen = 0;
      for (int t = 0; t < 60; t++) begin
         #2;
         if (log_q.size() > NP + 1) begin seen = 1; break; end
         @(negedge clk);
      end
      tests++; if (!seen) begin fails++; $display("FAIL rstmid_read: status read never issued"); end
      @(posedge clk); #1;
      reset = 1;
      @(posedge clk); #1;
      tests++; if ({avm_write, avm_read, rsp_valid, cmd_ready} !== 4'b0000) begin fails++; $display("FAIL rstmid_strobes: got %b want 0000", {avm_write, avm_read, rsp_valid, cmd_ready}); end
      tests++; if ({avm_address, rsp_data, rsp_status} !== '0) begin fails++; $display("FAIL rstmid_data: addr=%h rd=%h st=%0d want 0", avm_address, rsp_data, rsp_status); end
      tests++; if (rsp_q.size() !== 0) begin fails++; $display("FAIL rstmid_norsp: got %0d responses want 0", rsp_q.size()); end
      @(negedge clk);
      reset = 0;
      for (int i = 0; i < NP; i++) prm[i] = $urandom;
      scr.push_back(32'h0000_0002);
      model(32'h0000_0066, prm, scr);
      issue(32'h0000_0066, prm, scr, cc, ok);
      d = log_diff();
      tests++; if (d != -1 || !ok) begin fails++; $display("FAIL rstmid_recover: diff at %0d rsp=%0d want -1/1", d, ok); end
      $display("[TB] reset_mid recovered=%0d", ok);
   endtask

   task automatic test_cmd_hold();
      int acc, rsps, viol;
      bit busy;
      log_q.delete(); rsp_q.delete(); stat_q.delete();
      repeat (3) stat_q.push_back(32'h0000_0002);
      max_wait = 0;
      acc = 0; rsps = 0; viol = 0; busy = 0;
      @(negedge clk);
      cmd_code = 32'h0000_0077;
      cmd_valid = 1;
      for (int t = 0; t < 300; t++) begin
         #1;
         if (busy && cmd_ready !== 1'b0) viol++;
         if (rsp_valid === 1'b1) begin rsps++; busy = 0; end
         if (cmd_ready === 1'b1 && cmd_valid) begin acc++; busy = 1; end
         if (rsps == 3) break;
         @(negedge clk);
      end
      cmd_valid = 0;
      repeat (3) @(negedge clk);
      tests++; if (acc !== 3 || rsps !== 3) begin fails++; $display("FAIL hold_count: accepts=%0d rsps=%0d want 3/3", acc, rsps); end
      tests++; if (viol !== 0) begin fails++; $display("FAIL hold_ready: cmd_ready high %0d times while busy want 0", viol); end
      tests++; if (log_q.size() !== 3 * (NP + 3)) begin fails++; $display("FAIL hold_xacts: got %0d want %0d", log_q.size(), 3 * (NP + 3)); end
      $display("[TB] cmd_hold accepts=%0d rsps=%0d", acc, rsps);
   endtask

`ifdef SEQ_DBG_TIMEOUT_EN
   task automatic test_timeout();
      logic [31:0] prm [NP];
      logic [31:0] scr [$];
      int cc;
      bit ok;
      for (int i = 0; i < NP; i++) prm[i] = $urandom;
      max_wait = 0;
      issue(32'h0000_0088, prm, scr, cc, ok);
      tests++; if (!ok) begin fails++; $display("FAIL tmo_rsp: no rsp_valid, want one"); end
      else begin
         tests++; if (rsp_q[0].st !== 2'd2) begin fails++; $display("FAIL tmo_status: got %0d want 2", rsp_q[0].st); end
         tests++; if (log_q.size() <= NP || rsp_q[0].cyc - log_q[NP].cyc > TMO + POLL_GAP + 4) begin
            fails++; $display("FAIL tmo_bound: xacts=%0d want rsp within %0d cycles", log_q.size(), TMO + POLL_GAP + 4);
         end
         tests++; if (log_q[$].wr !== 1'b1 || log_q[$].addr !== STAT_ADDR || log_q[$].data !== 32'h0) begin
            fails++; $display("FAIL tmo_clear: last xact wr=%b addr=%h data=%h want 1/%h/0", log_q[$].wr, log_q[$].addr, log_q[$].data, STAT_ADDR);
         end
         $display("[TB] timeout status=%0d xacts=%0d", rsp_q[0].st, log_q.size());
      end
   endtask
`endif

   initial begin
      test_reset();
      test_basic();
      test_error_poll();
      test_waitrequest();
      test_reset_mid();
      test_cmd_hold();
`ifdef SEQ_DBG_TIMEOUT_EN
      test_timeout();
`endif
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end
endmodule
